window_read_sequencer: RTL and testbench

Sequences reads out of the overlapped-window input FIFO and delivers whole windows, one sample per beat, to the downstream windowing/FFT stage over a valid/ready stream. It drives the FIFO address manager's dequeue request and accepts its read strobe and last flag. It aligns RAM read data with the window index, and buffers enough samples to absorb RAM latency under downstream backpressure. It sits between the input queue (address manager plus sample RAM) and the window-function multiplier.

---
 rtl/window_read_sequencer.sv | 149 ++++++++++++++
 tb/tb_window_read_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_read_sequencer.sv
// Reads whole windows out of the overlapped-window FIFO and streams them one sample per beat.
// A RAM_LATENCY-deep tag pipe aligns RAM data with its index; a credit-gated skid buffer absorbs backpressure.
module window_read_sequencer #(
  parameter int ADDRWIDTH   = 12,
  parameter int DATAWIDTH   = 16,
  parameter int RAM_LATENCY = 1,
  parameter int BUF_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic                 dequeue,
  input  logic                 read,
  input  logic                 last,
  input  logic [ADDRWIDTH-1:0] window_addr,
  input  logic [DATAWIDTH-1:0] ram_rdata,
  output logic [DATAWIDTH-1:0] m_data,
  output logic [ADDRWIDTH-1:0] m_index,
  output logic                 m_first,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic [15:0]          frame_count
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + RAM_LATENCY + 2);
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  typedef struct packed {
    logic [ADDRWIDTH-1:0] idx;
    logic                 last;
  } tag_t;

  typedef struct packed {
    logic [DATAWIDTH-1:0] data;
    logic [ADDRWIDTH-1:0] idx;
    logic                 first;
    logic                 last;
  } beat_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_dequeue, w_dequeue_nxt;
  logic [RAM_LATENCY-1:0] r_vld_pipe;
  tag_t                   r_tag_pipe [RAM_LATENCY];
  beat_t                  r_buf [BUF_DEPTH];
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_occ, w_inflight, w_outstanding;
  logic [15:0]            r_frame_count;
  logic                   w_rd, w_push, w_pop, w_credit_ok, w_drained;
  tag_t                   w_tag_out;
  beat_t                  w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Only reads answering our own request enter the pipe.
  assign w_rd      = read && r_dequeue;
  assign w_push    = r_vld_pipe[RAM_LATENCY-1];
  assign w_tag_out = r_tag_pipe[RAM_LATENCY-1];
  assign w_head    = r_buf[r_rd_ptr];
  assign m_valid   = (r_occ != '0);
  assign w_pop     = m_valid && m_ready;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RAM_LATENCY; i++)
      w_inflight = w_inflight + CW'(r_vld_pipe[i]);
  end

  // Counting the request already on the wire keeps a read landing next cycle from overflowing the buffer.
  assign w_outstanding = w_inflight + r_occ + CW'(r_dequeue);
  assign w_credit_ok   = (w_outstanding < DEPTH_C);
  assign w_drained     = (w_inflight == '0) && ((r_occ == '0) || ((r_occ == ONE_C) && w_pop));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_dequeue <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dequeue <= w_dequeue_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dequeue_nxt = 1'b0;
    case (r_state)
      IDLE:   if (enable) w_state_nxt = STREAM;
      STREAM: begin
        // Request stays low once the final index is read so the window shift-back cannot race it.
        if (w_rd && last) w_state_nxt = DRAIN;
        else              w_dequeue_nxt = w_credit_ok;
      end
      DRAIN:  if (w_drained) w_state_nxt = enable ? STREAM : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) r_tag_pipe[i] <= '0;
    end else begin
      r_vld_pipe[0] <= w_rd;
      r_tag_pipe[0] <= tag_t'{window_addr, last};
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= beat_t'{ram_rdata, w_tag_out.idx, (w_tag_out.idx == '0), w_tag_out.last};
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_occ <= r_occ + ONE_C;
      else if (!w_push && w_pop) r_occ <= r_occ - ONE_C;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n)              r_frame_count <= '0;
    else if (w_pop && m_last)  r_frame_count <= r_frame_count + 16'd1;
  end

  assign dequeue     = r_dequeue;
  assign m_data      = w_head.data;
  assign m_index     = w_head.idx;
  assign m_first     = w_head.first;
  assign m_last      = w_head.last;
  assign busy        = (r_state != IDLE);
  assign frame_count = r_frame_count;
endmodule

// File: tb/tb_window_read_sequencer.sv
// Directed bench: models the address manager (hop 2047) and a 2-cycle sample RAM, scores every accepted beat.
module tb_window_read_sequencer;
  localparam int LAT = 2;
  localparam int BD  = 4;

  logic        clock, reset_n, enable, dequeue, read, last;
  logic [11:0] window_addr, m_index;
  logic [15:0] ram_rdata, m_data, frame_count;
  logic        m_first, m_last, m_valid, m_ready, busy;
  logic        tb_empty;

  window_read_sequencer #(.ADDRWIDTH(12), .DATAWIDTH(16), .RAM_LATENCY(LAT), .BUF_DEPTH(BD)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .dequeue(dequeue), .read(read), .last(last),
    .window_addr(window_addr), .ram_rdata(ram_rdata), .m_data(m_data), .m_index(m_index),
    .m_first(m_first), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .frame_count(frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] ram_val(input logic [15:0] a);
    return (a * 16'd40503) + 16'h1357;
  endfunction

  // Address manager and sample RAM environment.
  logic [11:0] am_idx;
  logic [15:0] am_base;
  logic [15:0] rd_pipe [LAT];
  assign read        = dequeue && !tb_empty;
  assign last        = (am_idx == 12'hFFF);
  assign window_addr = am_idx;
  assign ram_rdata   = rd_pipe[LAT-1];

  always @(posedge clock) begin
    if (!reset_n) begin
      am_idx  <= 12'd0;
      am_base <= 16'd0;
    end else if (read) begin
      if (last) begin
        am_idx  <= 12'd0;
        am_base <= am_base + 16'd2047;
      end else begin
        am_idx <= am_idx + 12'd1;
      end
    end
    rd_pipe[0] <= ram_val(am_base + {4'd0, am_idx});
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  int          checks, errors;
  int          exp_idx, exp_frames, outst, emp_cnt, zrun;
  logic [15:0] exp_base, st_data;
  logic [11:0] st_idx;
  bit          drain_f, stall_f, emp_done, gap_seen;
  logic [3:0]  pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model;
    exp_idx = 0; exp_base = 16'd0; exp_frames = 0; outst = 0;
    drain_f = 0; stall_f = 0;
  endtask

  // One clock: score the cycle at the falling edge, return just after the rising edge.
  task automatic cyc;
    @(negedge clock);
    if (stall_f) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, st_data);
      chk("stall_index", m_index, st_idx);
    end
    if (drain_f) chk("drain_dequeue", dequeue, 0);
    if (read) begin
      outst++;
      chk("outstanding_le_depth", (outst <= BD), 1);
      if (last) drain_f = 1;
    end
    stall_f = m_valid && !m_ready;
    st_data = m_data;
    st_idx  = m_index;
    if (m_valid && m_ready) begin
      chk("beat_index", m_index, exp_idx);
      chk("beat_data", m_data, ram_val(exp_base + 16'(exp_idx)));
      chk("beat_first", m_first, (exp_idx == 0));
      chk("beat_last", m_last, (exp_idx == 4095));
      outst--;
      if (exp_idx == 4095) begin
        exp_idx = 0; exp_base += 16'd2047; exp_frames++; drain_f = 0;
      end else begin
        exp_idx++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // mode 0: ready=1; mode 1: ready pattern 1,0,0,1; mode 2: ready=1, FIFO empty 10 cycles at index 2000.
  task automatic run_until(input int tgt_frames, input int tgt_idx, input int mode);
    int n;
    n = 0; emp_cnt = 0; emp_done = 0; gap_seen = 0; zrun = 0;
    while (!(exp_frames >= tgt_frames && exp_idx >= tgt_idx) && n < 20000) begin
      m_ready = (mode == 1) ? pat[n % 4] : 1'b1;
      if (mode == 2 && !emp_done && am_idx == 12'd2000) begin
        emp_cnt = 10; emp_done = 1;
      end
      if (emp_cnt == 3) chk("empty_dequeue_held", dequeue, 1);
      tb_empty = (emp_cnt > 0);
      if (emp_cnt > 0) emp_cnt--;
      cyc;
      zrun = m_valid ? 0 : zrun + 1;
      if (mode == 2 && emp_done && zrun >= 5) gap_seen = 1;
      n++;
    end
    m_ready = 1'b1; tb_empty = 1'b0;
    chk("run_budget", (n < 20000), 1);
  endtask

  task automatic chk_reset;
    chk("rst_dequeue", dequeue, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_first", m_first, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_index", m_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
  endtask

  initial begin
    checks = 0; errors = 0; pat = 4'b1001;
    reset_n = 1'b0; enable = 1'b0; m_ready = 1'b1; tb_empty = 1'b0;
    reset_model;
    cyc; cyc;
    reset_model;
    chk_reset;
    reset_n = 1'b1;

    // Single window, start-up timing and first-beat latency.
    enable = 1'b1;
    cyc;
    chk("start_busy", busy, 1);
    chk("start_dequeue_low", dequeue, 0);
    cyc;
    chk("start_dequeue_high", dequeue, 1);
    enable = 1'b0;
    cyc;
    chk("lat_valid_c1", m_valid, 0);
    cyc;
    chk("lat_valid_c2", m_valid, 0);
    cyc;
    chk("lat_valid_c3", m_valid, 1);
    chk("lat_first", m_first, 1);
    run_until(1, 0, 0);
    chk("w1_frame_count", frame_count, 1);
    cyc; cyc;
    chk("w1_idle", busy, 0);
    chk("w1_dequeue", dequeue, 0);

    // Back-to-back windows with enable held.
    enable = 1'b1;
    run_until(2, 0, 0);
    chk("b2b_no_idle", busy, 1);
    chk("b2b_frame_count", frame_count, 2);
    enable = 1'b0;
    run_until(3, 0, 0);
    cyc; cyc;
    chk("b2b_idle", busy, 0);
    chk("b2b_frame_count2", frame_count, 3);

    // Downstream stalls.
    enable = 1'b1;
    cyc;
    enable = 1'b0;
    run_until(4, 0, 1);
    chk("stall_frame_count", frame_count, 4);
    cyc; cyc;
    chk("stall_idle", busy, 0);

    // FIFO empty mid-window.
    enable = 1'b1;
    cyc;
    enable = 1'b0;
    run_until(5, 0, 2);
    chk("empty_gap_seen", gap_seen, 1);
    chk("empty_frame_count", frame_count, 5);

    // Reset at index 1000, then a clean window from index 0.
    enable = 1'b1;
    cyc;
    enable = 1'b0;
    run_until(5, 1000, 0);
    reset_n = 1'b0;
    cyc;
    reset_model;
    chk_reset;
    reset_n = 1'b1;
    cyc;
    chk("post_rst_busy", busy, 0);
    enable = 1'b1;
    cyc;
    enable = 1'b0;
    run_until(1, 0, 0);
    chk("post_rst_frame_count", frame_count, 1);

    // enable dropped at index 100: window still completes once.
    enable = 1'b1;
    cyc;
    run_until(1, 100, 0);
    enable = 1'b0;
    run_until(2, 0, 0);
    chk("en_drop_frame_count", frame_count, 2);
    cyc; cyc; cyc;
    chk("en_drop_idle", busy, 0);
    chk("en_drop_dequeue", dequeue, 0);
    chk("en_drop_frame_once", frame_count, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
